program_counter: RTL and testbench



---
 rtl/core_pkg.sv | 15 +
 rtl/program_counter_if.sv | 32 +++
 rtl/pc_next_logic.sv | 54 +++++
 rtl/program_counter.sv | 37 +++
 tb/tb_program_counter.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: address width, reset vector and the next-PC select encoding.
package core_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_BR   = 2'b01,
    PC_JALR = 2'b10,
    PC_HOLD = 2'b11
  } pc_sel_t;

endpackage

// File: rtl/program_counter_if.sv
// Fetch-side bundle between the control/decode logic (master) and the program counter (slave).
interface program_counter_if #(
  parameter int unsigned XLEN = 32
);
  import core_pkg::*;

  pc_sel_t             choice;
  logic [XLEN-1:0]     imm;
  logic [XLEN-1:0]     rs1;
  logic [XLEN-1:0]     pc_out;
  logic [XLEN-1:0]     pc_plus4;
  logic                misaligned;

  modport master (
    output choice,
    output imm,
    output rs1,
    input  pc_out,
    input  pc_plus4,
    input  misaligned
  );

  modport slave (
    input  choice,
    input  imm,
    input  rs1,
    output pc_out,
    output pc_plus4,
    output misaligned
  );

endinterface

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection, link value and target alignment flag.
module pc_next_logic #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]  pc,
  input  core_pkg::pc_sel_t choice,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1,
  output logic [XLEN-1:0]  next_pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             misaligned
);
  import core_pkg::*;

  logic [XLEN-1:0] seq_target;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_target;

  // All sums wrap modulo 2^XLEN; carries are dropped on purpose.
  always_comb begin
    seq_target  = pc + XLEN'(4);
    br_target   = pc + imm;
    jalr_sum    = rs1 + imm;
    jalr_target = {jalr_sum[XLEN-1:1], 1'b0};
  end

  assign pc_plus4 = seq_target;

  always_comb begin
    next_pc    = pc;
    misaligned = 1'b0;
    unique case (choice)
      PC_SEQ: begin
        next_pc = seq_target;
      end
      PC_BR: begin
        next_pc    = br_target;
        misaligned = (br_target[1:0] != 2'b00);
      end
      PC_JALR: begin
        next_pc    = jalr_target;
        misaligned = (jalr_target[1:0] != 2'b00);
      end
      PC_HOLD: begin
        next_pc = pc;
      end
      default: begin
        next_pc = pc;
      end
    endcase
  end

endmodule

// File: rtl/program_counter.sv
// Fetch-stage program counter: one flop bank with asynchronous active-low reset.
module program_counter #(
  parameter int unsigned    XLEN         = core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(core_pkg::RESET_VECTOR)
) (
  input  logic              clk,
  input  logic              reset,
  program_counter_if.slave  bus
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  pc_next_logic #(
    .XLEN(XLEN)
  ) u_next (
    .pc         (pc_q),
    .choice     (bus.choice),
    .imm        (bus.imm),
    .rs1        (bus.rs1),
    .next_pc    (pc_d),
    .pc_plus4   (bus.pc_plus4),
    .misaligned (bus.misaligned)
  );

  // Misaligned targets are still loaded; the control unit owns the trap decision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc_out = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: expected PCs queued at drive time, popped after each edge.
module tb_program_counter;
  import core_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic reset1;

  always #5 clk = ~clk;

  program_counter_if #(.XLEN(XLEN)) bus0 ();
  program_counter_if #(.XLEN(XLEN)) bus1 ();

  program_counter #(
    .XLEN(XLEN)
  ) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  program_counter #(
    .XLEN         (XLEN),
    .RESET_VECTOR (32'h0000_1000)
  ) dut1 (
    .clk   (clk),
    .reset (reset1),
    .bus   (bus1)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_pc;

  task automatic drive(input pc_sel_t sel, input logic [31:0] i, input logic [31:0] r,
                       input logic [31:0] exp);
    bus0.choice = sel;
    bus0.imm    = i;
    bus0.rs1    = r;
    sb.push_back(exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if (bus0.pc_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_pc got=%h exp=%h", bus0.pc_out, 32'h0);
    end
    checks++;
    if (bus0.pc_plus4 !== 32'h4) begin
      failures++;
      $display("FAIL reset_pc_plus4 got=%h exp=%h", bus0.pc_plus4, 32'h4);
    end
    checks++;
    if (bus0.misaligned !== 1'b0) begin
      failures++;
      $display("FAIL reset_misaligned got=%b exp=0", bus0.misaligned);
    end
  endtask

  task automatic test_sequential();
    reset = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      drive(PC_SEQ, $urandom, $urandom, 32'(i * 4));
      tick();
      exp_pc = sb.pop_front();
      checks++;
      if (bus0.pc_out !== exp_pc) begin
        failures++;
        $display("FAIL seq_step%0d got=%h exp=%h", i, bus0.pc_out, exp_pc);
      end
    end
  endtask

  task automatic test_branch();
    drive(PC_BR, 32'h0000_00C4, $urandom, 32'h100);
    tick();
    exp_pc = sb.pop_front();
    checks++;
    if (bus0.pc_out !== exp_pc) begin
      failures++;
      $display("FAIL br_setup got=%h exp=%h", bus0.pc_out, exp_pc);
    end
    drive(PC_BR, 32'hFFFF_FFF0, $urandom, 32'hF0);
    #1;
    checks++;
    if (bus0.misaligned !== 1'b0) begin
      failures++;
      $display("FAIL br_back_misaligned got=%b exp=0", bus0.misaligned);
    end
    tick();
    exp_pc = sb.pop_front();
    checks++;
    if (bus0.pc_out !== exp_pc) begin
      failures++;
      $display("FAIL br_back got=%h exp=%h", bus0.pc_out, exp_pc);
    end
    drive(PC_BR, 32'h10, $urandom, 32'h100);
    tick();
    exp_pc = sb.pop_front();
    checks++;
    if (bus0.pc_out !== exp_pc) begin
      failures++;
      $display("FAIL br_fwd got=%h exp=%h", bus0.pc_out, exp_pc);
    end
    drive(PC_BR, 32'h6, $urandom, 32'h106);
    #1;
    checks++;
    if (bus0.misaligned !== 1'b1) begin
      failures++;
      $display("FAIL br_odd_misaligned got=%b exp=1", bus0.misaligned);
    end
    tick();
    exp_pc = sb.pop_front();
    checks++;
    if (bus0.pc_out !== exp_pc) begin
      failures++;
      $display("FAIL br_odd got=%h exp=%h", bus0.pc_out, exp_pc);
    end
  endtask

  task automatic test_jalr();
    drive(PC_JALR, 32'h4, 32'h2001, 32'h2004);
    #1;
    checks++;
    if (bus0.misaligned !== 1'b0) begin
      failures++;
      $display("FAIL jalr_even_misaligned got=%b exp=0", bus0.misaligned);
    end
    tick();
    exp_pc = sb.pop_front();
    checks++;
    if (bus0.pc_out !== exp_pc) begin
      failures++;
      $display("FAIL jalr_even got=%h exp=%h", bus0.pc_out, exp_pc);
    end
    drive(PC_JALR, 32'h4, 32'h2003, 32'h2006);
    #1;
    checks++;
    if (bus0.misaligned !== 1'b1) begin
      failures++;
      $display("FAIL jalr_odd_misaligned got=%b exp=1", bus0.misaligned);
    end
    tick();
    exp_pc = sb.pop_front();
    checks++;
    if (bus0.pc_out !== exp_pc) begin
      failures++;
      $display("FAIL jalr_odd got=%h exp=%h", bus0.pc_out, exp_pc);
    end
    // Sequential from an unaligned PC: operands ignored and no flag for choice 00.
    drive(PC_SEQ, 32'h3, 32'h5, 32'h200A);
    #1;
    checks++;
    if (bus0.misaligned !== 1'b0) begin
      failures++;
      $display("FAIL seq_flag got=%b exp=0", bus0.misaligned);
    end
    tick();
    exp_pc = sb.pop_front();
    checks++;
    if (bus0.pc_out !== exp_pc) begin
      failures++;
      $display("FAIL seq_ignore_ops got=%h exp=%h", bus0.pc_out, exp_pc);
    end
  endtask

  task automatic test_hold();
    drive(PC_JALR, 32'h0, 32'h40, 32'h40);
    tick();
    exp_pc = sb.pop_front();
    checks++;
    if (bus0.pc_out !== exp_pc) begin
      failures++;
      $display("FAIL hold_setup got=%h exp=%h", bus0.pc_out, exp_pc);
    end
    for (int i = 0; i < 5; i++) begin
      drive(PC_HOLD, $urandom | 32'h1, $urandom | 32'h1, 32'h40);
      #1;
      checks++;
      if (bus0.misaligned !== 1'b0) begin
        failures++;
        $display("FAIL hold_flag%0d got=%b exp=0", i, bus0.misaligned);
      end
      tick();
      exp_pc = sb.pop_front();
      checks++;
      if (bus0.pc_out !== exp_pc || bus0.pc_plus4 !== 32'h44) begin
        failures++;
        $display("FAIL hold%0d got pc=%h plus4=%h exp pc=%h plus4=%h", i, bus0.pc_out,
                 bus0.pc_plus4, exp_pc, 32'h44);
      end
    end
  endtask

  task automatic test_wrap();
    drive(PC_JALR, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    tick();
    exp_pc = sb.pop_front();
    checks++;
    if (bus0.pc_out !== exp_pc) begin
      failures++;
      $display("FAIL wrap_setup got=%h exp=%h", bus0.pc_out, exp_pc);
    end
    checks++;
    if (bus0.pc_plus4 !== 32'h0) begin
      failures++;
      $display("FAIL wrap_plus4 got=%h exp=%h", bus0.pc_plus4, 32'h0);
    end
    drive(PC_SEQ, $urandom, $urandom, 32'h0);
    tick();
    exp_pc = sb.pop_front();
    checks++;
    if (bus0.pc_out !== exp_pc) begin
      failures++;
      $display("FAIL wrap got=%h exp=%h", bus0.pc_out, exp_pc);
    end
  endtask

  task automatic test_async_reset();
    drive(PC_JALR, 32'h0, 32'h80, 32'h80);
    tick();
    exp_pc = sb.pop_front();
    checks++;
    if (bus0.pc_out !== exp_pc) begin
      failures++;
      $display("FAIL arst_setup got=%h exp=%h", bus0.pc_out, exp_pc);
    end
    bus0.choice = PC_BR;
    bus0.imm    = 32'h40;
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (bus0.pc_out !== 32'h0 || bus0.pc_plus4 !== 32'h4) begin
      failures++;
      $display("FAIL arst_midcycle got pc=%h plus4=%h exp pc=%h plus4=%h", bus0.pc_out,
               bus0.pc_plus4, 32'h0, 32'h4);
    end
    tick();
    checks++;
    if (bus0.pc_out !== 32'h0) begin
      failures++;
      $display("FAIL arst_held got=%h exp=%h", bus0.pc_out, 32'h0);
    end
    reset = 1'b1;
    drive(PC_SEQ, 32'h0, 32'h0, 32'h4);
    tick();
    exp_pc = sb.pop_front();
    checks++;
    if (bus0.pc_out !== exp_pc) begin
      failures++;
      $display("FAIL arst_release got=%h exp=%h", bus0.pc_out, exp_pc);
    end
  endtask

  task automatic test_reset_vector();
    checks++;
    if (bus1.pc_out !== 32'h1000) begin
      failures++;
      $display("FAIL rv_reset got=%h exp=%h", bus1.pc_out, 32'h1000);
    end
    bus1.choice = PC_SEQ;
    reset1      = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      sb.push_back(32'h1000 + 32'(i * 4));
      tick();
      exp_pc = sb.pop_front();
      checks++;
      if (bus1.pc_out !== exp_pc) begin
        failures++;
        $display("FAIL rv_step%0d got=%h exp=%h", i, bus1.pc_out, exp_pc);
      end
    end
    #3;
    reset1 = 1'b0;
    #1;
    checks++;
    if (bus1.pc_out !== 32'h1000) begin
      failures++;
      $display("FAIL rv_midcycle got=%h exp=%h", bus1.pc_out, 32'h1000);
    end
    tick();
    checks++;
    if (bus1.pc_out !== 32'h1000) begin
      failures++;
      $display("FAIL rv_held got=%h exp=%h", bus1.pc_out, 32'h1000);
    end
  endtask

  initial begin
    reset       = 1'b1;
    reset1      = 1'b1;
    bus0.choice = PC_HOLD;
    bus0.imm    = 32'h0;
    bus0.rs1    = 32'h0;
    bus1.choice = PC_HOLD;
    bus1.imm    = 32'h0;
    bus1.rs1    = 32'h0;
    #2;
    reset  = 1'b0;
    reset1 = 1'b0;
    test_reset();
    test_sequential();
    test_branch();
    test_jalr();
    test_hold();
    test_wrap();
    test_async_reset();
    test_reset_vector();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
